tx0_petr_ctl: RTL and testbench
===============================

Name: tx0_petr_ctl

Overview:
- Sequencer for the TX-0 photoelectric tape reader (PETR).
- Receives the read-one-line and read-three-lines IO requests decoded in the CPU operate cycle and fetches 6-bit tape lines over a valid/ready handshake.
- Drives the accumulator's strobe_petr (OR into ac bits 0,3,6,9,12,15) and cycle-right controls in sequence.
- Signals IO completion so the CPU's IO-stop flip-flop (ios) restarts.

Parameters:
- LINE_GAP, 4, idle cycles enforced after each accepted line before the next tape_ready (reader speed model); 0 = no gap.
- FEED_GAP, 4, idle cycles between discarded lines during tape feed.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- read_1_line  in  1  one-cycle request: read one line (any hole pattern)
- read_3_lines  in  1  one-cycle request: read three binary lines
- btn_tape_feed  in  1  level; advance and discard tape while high and idle
- tape_valid  in  1  reader presents a line
- tape_data  in  [0:5]  hole pattern, bit 0 = channel 1
- tape_7th  in  1  7th (binary-mode) hole
- tape_ready  out  1  controller accepts the line this cycle
- petr  out  [0:5]  latched line to AC strobe gates
- strobe_petr  out  1  one-cycle pulse: OR petr into AC
- cycle_ac  out  1  one-cycle pulse: cycle AC right one place
- io_complete  out  1  one-cycle pulse to io_restart
- busy  out  1  high in every non-IDLE state

Behaviour:
- Reset values: all pulse outputs 0, tape_ready 0, busy 0, petr 6'b000000, state IDLE, line counter 0, gap counter 0.
- States: IDLE, WAIT, STROBE, CYCLE, GAP, DONE, FEED, FEED_GAP.
- IDLE transitions:
  - read_3_lines -> WAIT with remaining=3, mode=binary.
  - read_1_line -> WAIT with remaining=1, mode=any.
  - Both in the same cycle: read_3_lines wins.
  - btn_tape_feed with no request -> FEED.
- WAIT:
  - tape_ready=1.
  - The handshake fires when tape_valid & tape_ready.
  - On handshake, capture tape_data into petr.
  - If mode=binary and tape_7th=0, the line is skipped: go to GAP, remaining unchanged, no strobe.
  - Otherwise go to STROBE.
  - No timeout; the controller waits indefinitely.
- STROBE: strobe_petr=1 for one cycle -> CYCLE.
- CYCLE: cycle_ac=1 for one cycle; remaining -= 1 -> GAP.
- GAP:
  - Holds for LINE_GAP cycles (0 = zero cycles, evaluated the same cycle).
  - Then remaining>0 -> WAIT; remaining=0 -> DONE.
- DONE: io_complete=1 for one cycle -> IDLE.
- Latency: the handshake in cycle N gives strobe_petr at N+1 and cycle_ac at N+2. With LINE_GAP=0 and remaining=0, io_complete follows at N+3.
- FEED:
  - tape_ready=1.
  - Each handshake discards the line and goes to FEED_GAP (FEED_GAP cycles) -> FEED.
  - btn_tape_feed low in FEED or at the end of FEED_GAP -> IDLE.
  - No strobe, cycle or io_complete is generated during feed.
- Requests arriving while not IDLE are ignored, including during FEED.
- petr holds its last value until the next handshake.
- tape_ready is never high outside WAIT and FEED.
- Remaining counter is 2 bits and never wraps: the decrement happens only in CYCLE with remaining≥1.
- Reset asserted mid-operation: immediate return to IDLE, no io_complete, tape_ready drops the same cycle; the AC keeps any partial line data already ORed in.

Decomposition:
- Shared package tx0_pkg:
  - petr_state_t enum (8 states).
  - Constants PETR_LINES_R3=3, PETR_LINES_R1=1, PETR_W=6.
- One sub-module is natural: tx0_gap_timer (loadable down-counter with a done flag), used for both GAP and FEED_GAP.

Test Plan:
- LINE_GAP=0; read_1_line; one line 6'o52 with 7th=0 offered immediately → tape_ready at N, strobe_petr at N+1 with petr=6'o52, cycle_ac at N+2, io_complete at N+3, busy low at N+4.
- read_3_lines; lines offered: 6'o77/7th=1, 6'o00/7th=0, 6'o15/7th=1, 6'o41/7th=1 → exactly 3 strobes with petr 77, 15, 41, in order; 3 cycle_ac pulses; the 7th=0 line is consumed with no strobe; one io_complete.
- read_1_line and read_3_lines asserted in the same cycle → three-line sequence runs, one io_complete. A second read_1_line while busy → no effect.
- LINE_GAP=4; read_3_lines with tape_valid held high → consecutive handshakes spaced exactly 7 cycles apart (1 WAIT + 1 STROBE + 1 CYCLE + 4 GAP).
- btn_tape_feed high for 20 cycles, FEED_GAP=4, tape_valid constant → 4 lines accepted; strobe_petr, cycle_ac and io_complete all stay 0; IDLE after the button is released.
- Reset pulsed after the first strobe of read_3_lines → all outputs return to reset values asynchronously; no io_complete. A new read_1_line afterwards completes normally.

Source files
------------

// File: rtl/tx0_pkg.sv
// Shared types and constants for the TX-0 photoelectric tape reader controller.
package tx0_pkg;

  localparam int PETR_W        = 6;
  localparam int PETR_LINES_R3 = 3;
  localparam int PETR_LINES_R1 = 1;

  typedef enum logic [2:0] {
    PS_IDLE     = 3'd0,
    PS_WAIT     = 3'd1,
    PS_STROBE   = 3'd2,
    PS_CYCLE    = 3'd3,
    PS_GAP      = 3'd4,
    PS_DONE     = 3'd5,
    PS_FEED     = 3'd6,
    PS_FEED_GAP = 3'd7
  } petr_state_t;

  typedef logic [1:0] petr_cnt_t;

endpackage

// File: rtl/tx0_gap_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module tx0_gap_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/tx0_petr_ctl.sv
// TX-0 PETR sequencer: fetches tape lines, strobes them into AC, cycles AC,
// and signals IO completion; also handles the tape-feed button.
module tx0_petr_ctl
  import tx0_pkg::*;
#(
  parameter int LINE_GAP = 4,
  parameter int FEED_GAP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_1_line,
  input  logic              read_3_lines,
  input  logic              btn_tape_feed,
  input  logic              tape_valid,
  input  logic [0:PETR_W-1] tape_data,
  input  logic              tape_7th,
  output logic              tape_ready,
  output logic [0:PETR_W-1] petr,
  output logic              strobe_petr,
  output logic              cycle_ac,
  output logic              io_complete,
  output logic              busy
);

  localparam int GAP_MAX = (LINE_GAP > FEED_GAP) ? LINE_GAP : FEED_GAP;
  localparam int GAP_W   = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX);
  // The timer is loaded with gap-1 so the GAP state lasts exactly gap cycles.
  localparam logic [GAP_W-1:0] LINE_LD = (LINE_GAP > 0) ? GAP_W'(LINE_GAP - 1) : '0;
  localparam logic [GAP_W-1:0] FEED_LD = (FEED_GAP > 0) ? GAP_W'(FEED_GAP - 1) : '0;

  petr_state_t       state_q, state_d;
  petr_cnt_t         rem_q, rem_d, rem_dec;
  logic              bin_q, bin_d;
  logic [0:PETR_W-1] petr_q, petr_d;
  logic              gap_load;
  logic [GAP_W-1:0]  gap_val;
  logic              gap_done;
  logic              ready;
  logic              hs;

  tx0_gap_timer #(.CNT_W(GAP_W)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (gap_val),
    .done     (gap_done)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    bin_d    = bin_q;
    petr_d   = petr_q;
    gap_load = 1'b0;
    gap_val  = LINE_LD;
    ready    = (state_q == PS_WAIT) || (state_q == PS_FEED);
    hs       = ready && tape_valid;
    rem_dec  = (rem_q != 2'd0) ? rem_q - 2'd1 : rem_q;

    case (state_q)
      PS_IDLE: begin
        if (read_3_lines) begin
          state_d = PS_WAIT;
          rem_d   = petr_cnt_t'(PETR_LINES_R3);
          bin_d   = 1'b1;
        end else if (read_1_line) begin
          state_d = PS_WAIT;
          rem_d   = petr_cnt_t'(PETR_LINES_R1);
          bin_d   = 1'b0;
        end else if (btn_tape_feed) begin
          state_d = PS_FEED;
        end
      end
      PS_WAIT: begin
        if (hs) begin
          petr_d = tape_data;
          // Binary mode ignores lines without the 7th hole; they still consume tape.
          if (bin_q && !tape_7th) begin
            if (LINE_GAP == 0) begin
              state_d = PS_WAIT;
            end else begin
              state_d  = PS_GAP;
              gap_load = 1'b1;
            end
          end else begin
            state_d = PS_STROBE;
          end
        end
      end
      PS_STROBE: state_d = PS_CYCLE;
      PS_CYCLE: begin
        rem_d = rem_dec;
        if (LINE_GAP == 0) begin
          state_d = (rem_dec == 2'd0) ? PS_DONE : PS_WAIT;
        end else begin
          state_d  = PS_GAP;
          gap_load = 1'b1;
        end
      end
      PS_GAP: begin
        if (gap_done) begin
          state_d = (rem_q == 2'd0) ? PS_DONE : PS_WAIT;
        end
      end
      PS_DONE: state_d = PS_IDLE;
      PS_FEED: begin
        if (!btn_tape_feed) begin
          state_d = PS_IDLE;
        end else if (hs && (FEED_GAP != 0)) begin
          state_d  = PS_FEED_GAP;
          gap_load = 1'b1;
          gap_val  = FEED_LD;
        end
      end
      PS_FEED_GAP: begin
        if (gap_done) begin
          state_d = btn_tape_feed ? PS_FEED : PS_IDLE;
        end
      end
      default: state_d = PS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PS_IDLE;
      rem_q   <= '0;
      bin_q   <= 1'b0;
      petr_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bin_q   <= bin_d;
      petr_q  <= petr_d;
    end
  end

  assign tape_ready  = ready;
  assign petr        = petr_q;
  assign strobe_petr = (state_q == PS_STROBE);
  assign cycle_ac    = (state_q == PS_CYCLE);
  assign io_complete = (state_q == PS_DONE);
  assign busy        = (state_q != PS_IDLE);

endmodule

// File: tb/tb_tx0_petr_ctl.sv
// Bench for tx0_petr_ctl: two instances (LINE_GAP 0 and 4), a tape reader model
// and a transaction-level timing model of the read and feed sequences.
module tb_tx0_petr_ctl;

  localparam int FG  = 4;
  localparam int LG1 = 4;

  typedef struct {
    logic [0:5] val;
    logic       b7;
  } line_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       r1[2], r3[2], fb[2], tv[2], t7[2];
  logic       tr[2], stb[2], cac[2], ioc[2], bsy[2];
  logic [0:5] td[2], po[2];

  tx0_petr_ctl #(.LINE_GAP(0), .FEED_GAP(FG)) u_g0 (
    .clk(clk), .reset(reset), .read_1_line(r1[0]), .read_3_lines(r3[0]),
    .btn_tape_feed(fb[0]), .tape_valid(tv[0]), .tape_data(td[0]), .tape_7th(t7[0]),
    .tape_ready(tr[0]), .petr(po[0]), .strobe_petr(stb[0]), .cycle_ac(cac[0]),
    .io_complete(ioc[0]), .busy(bsy[0])
  );

  tx0_petr_ctl #(.LINE_GAP(LG1), .FEED_GAP(FG)) u_g4 (
    .clk(clk), .reset(reset), .read_1_line(r1[1]), .read_3_lines(r3[1]),
    .btn_tape_feed(fb[1]), .tape_valid(tv[1]), .tape_data(td[1]), .tape_7th(t7[1]),
    .tape_ready(tr[1]), .petr(po[1]), .strobe_petr(stb[1]), .cycle_ac(cac[1]),
    .io_complete(ioc[1]), .busy(bsy[1])
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int         checks = 0;
  int         errors = 0;
  int         mon_d  = 0;
  bit         tv_const = 1'b0;
  bit         hs_pend  = 1'b0;
  line_t      line_q[$];
  int         hs_c[$], stb_c[$], cac_c[$], ioc_c[$];
  logic [0:5] stb_v[$];
  int         busy_fall = -1;
  bit         busy_prev = 1'b0;

  // Event log of the monitored instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (tv[mon_d] && tr[mon_d]) begin
      hs_c.push_back(cyc_n);
      hs_pend = 1'b1;
    end
    if (stb[mon_d]) begin
      stb_c.push_back(cyc_n);
      stb_v.push_back(po[mon_d]);
    end
    if (cac[mon_d]) cac_c.push_back(cyc_n);
    if (ioc[mon_d]) ioc_c.push_back(cyc_n);
    if (busy_prev && !bsy[mon_d] && busy_fall < 0) busy_fall = cyc_n;
    busy_prev = bsy[mon_d];
  end

  // Tape reader: presents the head of line_q, advances after each accepted line.
  always @(posedge clk) begin
    #1;
    if (hs_pend) begin
      if (line_q.size() > 0) line_q.delete(0);
      hs_pend = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      if (d != mon_d) begin
        tv[d] = 1'b0; td[d] = '0; t7[d] = 1'b0;
      end
    end
    if (tv_const) begin
      tv[mon_d] = 1'b1;
      td[mon_d] = 6'($urandom);
      t7[mon_d] = 1'($urandom);
    end else if (line_q.size() > 0) begin
      tv[mon_d] = 1'b1;
      td[mon_d] = line_q[0].val;
      t7[mon_d] = line_q[0].b7;
    end else begin
      tv[mon_d] = 1'b0;
      td[mon_d] = '0;
      t7[mon_d] = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hs_c.delete(); stb_c.delete(); stb_v.delete(); cac_c.delete(); ioc_c.delete();
    busy_fall = -1;
    busy_prev = bsy[mon_d];
  endtask

  task automatic push_line(input logic [0:5] v, input logic b);
    line_t l;
    l.val = v;
    l.b7  = b;
    line_q.push_back(l);
  endtask

  // Issues a request on instance d, lets it finish, and compares the event log
  // against timings derived from the line list and the instance's line gap.
  task automatic run_read(input int d, input bit do_r3, input bit do_r1, input int g,
                          input int poke, input string tag);
    line_t      lines[$];
    int         e_hs[$], e_stb[$], e_cac[$];
    logic [0:5] e_val[$];
    int         rq, rem, t, n;
    lines = line_q;
    mon_d = d;
    tick();
    clear_logs();
    r3[d] = do_r3; r1[d] = do_r1; rq = cyc_n;
    tick();
    r3[d] = 1'b0; r1[d] = 1'b0;
    if (poke > 0) begin
      repeat (poke) tick();
      r1[d] = 1'b1; r3[d] = 1'b1;
      tick();
      r1[d] = 1'b0; r3[d] = 1'b0;
    end
    n = 0;
    while (ioc_c.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    line_q.delete();

    rem = do_r3 ? 3 : 1;
    t   = rq + 1;
    for (int i = 0; i < lines.size(); i++) begin
      if (rem > 0) begin
        e_hs.push_back(t);
        if (do_r3 && !lines[i].b7) begin
          t = t + 1 + g;
        end else begin
          e_stb.push_back(t + 1);
          e_val.push_back(lines[i].val);
          e_cac.push_back(t + 2);
          rem--;
          t = t + 3 + g;
        end
      end
    end

    checks++;
    if (hs_c.size() != e_hs.size()) begin
      errors++;
      $display("FAIL %s hs_count got %0d want %0d", tag, hs_c.size(), e_hs.size());
    end
    for (int i = 0; i < e_hs.size() && i < hs_c.size(); i++) begin
      checks++;
      if (hs_c[i] !== e_hs[i]) begin
        errors++;
        $display("FAIL %s hs_cycle[%0d] got %0d want %0d", tag, i, hs_c[i], e_hs[i]);
      end
    end
    checks++;
    if (stb_c.size() != e_stb.size()) begin
      errors++;
      $display("FAIL %s strobe_count got %0d want %0d", tag, stb_c.size(), e_stb.size());
    end
    for (int i = 0; i < e_stb.size() && i < stb_c.size(); i++) begin
      checks += 2;
      if (stb_c[i] !== e_stb[i]) begin
        errors++;
        $display("FAIL %s strobe_cycle[%0d] got %0d want %0d", tag, i, stb_c[i], e_stb[i]);
      end
      if (stb_v[i] !== e_val[i]) begin
        errors++;
        $display("FAIL %s petr[%0d] got %o want %o", tag, i, stb_v[i], e_val[i]);
      end
    end
    checks++;
    if (cac_c.size() != e_cac.size()) begin
      errors++;
      $display("FAIL %s cycle_ac_count got %0d want %0d", tag, cac_c.size(), e_cac.size());
    end
    for (int i = 0; i < e_cac.size() && i < cac_c.size(); i++) begin
      checks++;
      if (cac_c[i] !== e_cac[i]) begin
        errors++;
        $display("FAIL %s cycle_ac[%0d] got %0d want %0d", tag, i, cac_c[i], e_cac[i]);
      end
    end
    checks++;
    if (ioc_c.size() != 1) begin
      errors++;
      $display("FAIL %s io_complete_count got %0d want 1", tag, ioc_c.size());
    end else begin
      checks++;
      if (ioc_c[0] !== t) begin
        errors++;
        $display("FAIL %s io_complete_cycle got %0d want %0d", tag, ioc_c[0], t);
      end
    end
    checks++;
    if (busy_fall !== t + 1) begin
      errors++;
      $display("FAIL %s busy_fall got %0d want %0d", tag, busy_fall, t + 1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks += 6;
      if (tr[d] !== 1'b0)   begin errors++; $display("FAIL rst_ready[%0d] got %b want 0", d, tr[d]); end
      if (stb[d] !== 1'b0)  begin errors++; $display("FAIL rst_strobe[%0d] got %b want 0", d, stb[d]); end
      if (cac[d] !== 1'b0)  begin errors++; $display("FAIL rst_cycle[%0d] got %b want 0", d, cac[d]); end
      if (ioc[d] !== 1'b0)  begin errors++; $display("FAIL rst_ioc[%0d] got %b want 0", d, ioc[d]); end
      if (bsy[d] !== 1'b0)  begin errors++; $display("FAIL rst_busy[%0d] got %b want 0", d, bsy[d]); end
      if (po[d] !== 6'o00)  begin errors++; $display("FAIL rst_petr[%0d] got %o want 0", d, po[d]); end
    end
    tick();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks += 2;
      if (bsy[d] !== 1'b0) begin errors++; $display("FAIL idle_busy[%0d] got %b want 0", d, bsy[d]); end
      if (tr[d] !== 1'b0)  begin errors++; $display("FAIL idle_ready[%0d] got %b want 0", d, tr[d]); end
    end
  endtask

  task automatic test_single();
    push_line(6'o52, 1'b0);
    run_read(0, 1'b0, 1'b1, 0, 0, "r1_o52");
    for (int k = 0; k < 3; k++) begin
      push_line(6'($urandom), 1'($urandom));
      run_read(0, 1'b0, 1'b1, 0, 0, "r1_rand");
    end
  endtask

  task automatic test_three();
    int nb;
    push_line(6'o77, 1'b1);
    push_line(6'o00, 1'b0);
    push_line(6'o15, 1'b1);
    push_line(6'o41, 1'b1);
    run_read(0, 1'b1, 1'b0, 0, 0, "r3_fixed");
    for (int k = 0; k < 3; k++) begin
      nb = 0;
      for (int i = 0; i < 10 && nb < 3; i++) begin
        logic b;
        b = (i >= 5) ? 1'b1 : 1'($urandom);
        push_line(6'($urandom), b);
        if (b) nb++;
      end
      push_line(6'($urandom), 1'b1);
      run_read(0, 1'b1, 1'b0, 0, 0, "r3_rand");
    end
  endtask

  task automatic test_both_same();
    for (int k = 0; k < 2; k++) begin
      push_line(6'($urandom), 1'b1);
      push_line(6'($urandom), 1'b0);
      push_line(6'($urandom), 1'b1);
      push_line(6'($urandom), 1'b1);
      run_read(0, 1'b1, 1'b1, 0, 2, "r1r3_busy_req");
    end
  endtask

  task automatic test_spacing();
    for (int i = 0; i < 3; i++) push_line(6'($urandom), 1'b1);
    run_read(1, 1'b1, 1'b0, LG1, 0, "gap4");
    for (int i = 1; i < hs_c.size(); i++) begin
      checks++;
      if (hs_c[i] - hs_c[i-1] !== 3 + LG1) begin
        errors++;
        $display("FAIL gap4_spacing[%0d] got %0d want %0d", i, hs_c[i] - hs_c[i-1], 3 + LG1);
      end
    end
    push_line(6'($urandom), 1'b0);
    run_read(1, 1'b0, 1'b1, LG1, 0, "gap4_r1");
  endtask

  task automatic test_feed();
    int b0, t;
    int e_hs[$];
    mon_d = 0;
    tv_const = 1'b1;
    tick();
    clear_logs();
    b0 = cyc_n;
    for (int k = 0; k < 20; k++) begin
      fb[0] = 1'b1;
      r1[0] = (k == 7);
      tick();
    end
    fb[0] = 1'b0;
    r1[0] = 1'b0;
    repeat (5) @(negedge clk);
    tv_const = 1'b0;
    // Button is high for cycles b0..b0+19; each accepted line is followed by FG gap cycles.
    t = b0 + 1;
    while (t <= b0 + 19) begin
      e_hs.push_back(t);
      if (t + FG > b0 + 19) break;
      t = t + FG + 1;
    end
    checks++;
    if (hs_c.size() != e_hs.size()) begin
      errors++;
      $display("FAIL feed_lines got %0d want %0d", hs_c.size(), e_hs.size());
    end
    for (int i = 0; i < e_hs.size() && i < hs_c.size(); i++) begin
      checks++;
      if (hs_c[i] !== e_hs[i]) begin
        errors++;
        $display("FAIL feed_hs[%0d] got %0d want %0d", i, hs_c[i], e_hs[i]);
      end
    end
    checks += 4;
    if (stb_c.size() != 0) begin errors++; $display("FAIL feed_strobe got %0d want 0", stb_c.size()); end
    if (cac_c.size() != 0) begin errors++; $display("FAIL feed_cycle got %0d want 0", cac_c.size()); end
    if (ioc_c.size() != 0) begin errors++; $display("FAIL feed_ioc got %0d want 0", ioc_c.size()); end
    if (busy_fall !== b0 + 21) begin
      errors++;
      $display("FAIL feed_idle got %0d want %0d", busy_fall, b0 + 21);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mon_d = 0;
    for (int i = 0; i < 4; i++) push_line(6'($urandom_range(1, 63)), 1'b1);
    tick();
    clear_logs();
    r3[0] = 1'b1;
    tick();
    r3[0] = 1'b0;
    n = 0;
    while (stb_c.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2 reset = 1'b1;
    #1;
    checks += 6;
    if (tr[0] !== 1'b0)  begin errors++; $display("FAIL mid_ready got %b want 0", tr[0]); end
    if (stb[0] !== 1'b0) begin errors++; $display("FAIL mid_strobe got %b want 0", stb[0]); end
    if (cac[0] !== 1'b0) begin errors++; $display("FAIL mid_cycle got %b want 0", cac[0]); end
    if (ioc[0] !== 1'b0) begin errors++; $display("FAIL mid_ioc got %b want 0", ioc[0]); end
    if (bsy[0] !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", bsy[0]); end
    if (po[0] !== 6'o00) begin errors++; $display("FAIL mid_petr got %o want 0", po[0]); end
    #1 reset = 1'b0;
    line_q.delete();
    repeat (20) @(negedge clk);
    checks += 2;
    if (ioc_c.size() != 0) begin errors++; $display("FAIL mid_no_ioc got %0d want 0", ioc_c.size()); end
    if (bsy[0] !== 1'b0)   begin errors++; $display("FAIL mid_idle got %b want 0", bsy[0]); end
    push_line(6'($urandom), 1'($urandom));
    run_read(0, 1'b0, 1'b1, 0, 0, "after_reset_r1");
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      r1[d] = 1'b0; r3[d] = 1'b0; fb[d] = 1'b0;
      tv[d] = 1'b0; t7[d] = 1'b0; td[d] = '0;
    end
    #1 reset = 1'b1;
    test_reset();
    test_single();
    test_three();
    test_both_same();
    test_spacing();
    test_feed();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

endmodule
